gcd_unit: RTL and testbench
===========================

# gcd_unit

Parametrised, self-sequencing GCD engine: accepts an operand pair over a valid/ready handshake, iterates to the greatest common divisor with an internal datapath and FSM, and presents the result over a second valid/ready handshake. It is the next-generation GCD block for the lab datapath library. It adds run-time-free width selection, a choice between subtractive and binary (Stein) algorithms, zero-operand handling and an iteration counter.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- CNT_W, 16, width of the iteration counter `steps`
- MODE, 0, algorithm: 0 = subtractive (Euclid), 1 = binary (Stein)

- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair X/Y valid
- in_ready  output  1  block can accept an operand pair
- X  input  WIDTH  first operand, unsigned
- Y  input  WIDTH  second operand, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out  output  WIDTH  GCD result, registered
- steps  output  CNT_W  iteration count of the last/current computation, registered
- busy  output  1  high in RUN

## Operation
- States: IDLE, RUN, DONE. Internal registers: x, y (WIDTH), k (shift count, clog2(WIDTH)+1 bits), steps.
- IDLE: in_ready=1. If in_valid is high at an edge, then x←X, y←Y, k←0, steps←0, and state→RUN.
- RUN: in_ready=0, busy=1. Priority order, evaluated each cycle:
  - If x==0 or y==0: out←(x|y)<<k, state→DONE. Both zero gives out=0. This can only occur on the first RUN cycle, so k=0 there.
  - Else if x==y: out←x<<k, state→DONE.
  - Else perform one step and increment steps. steps saturates at all-ones and never wraps.
    - MODE 0: if x>y then x←x−y, else y←y−x.
    - MODE 1, in this order:
      - both even: x←x>>1, y←y>>1, k←k+1
      - x even: x←x>>1
      - y even: y←y>>1
      - x>y: x←x−y
      - otherwise: y←y−x
- Terminal cycles (zero or equal) do not increment steps.
- DONE: out_valid=1. out and steps are held stable. If out_ready is high at an edge, state→IDLE.
- in_ready is low in DONE. A new pair cannot be accepted in the same cycle the result is consumed; there is one IDLE cycle minimum between results.
- out and steps keep their values in IDLE until overwritten by the next computation. steps is cleared at accept.
- All arithmetic is unsigned and WIDTH-bit. Subtraction is only performed larger-minus-smaller, so no underflow occurs. In MODE 1, k < WIDTH always, and out = x<<k cannot overflow because the true GCD fits in WIDTH bits.
- X and Y are sampled only at the accept edge. Later changes are ignored.

## Timing
- Reset (reset low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out=0, steps=0, x=y=k=0.
- Reset mid-RUN or in DONE: the computation is abandoned and the result is not presented. On release the block is in IDLE.
- Accept at edge E0. For S step cycles, RUN lasts S+1 cycles, and out_valid rises after edge E0+S+1.
- Zero or equal operands: S=0, out_valid after E0+1.
- out_valid stays high indefinitely while out_ready is low. It drops at the edge where out_ready is sampled high.
- in_ready is combinational from the state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- MODE 0, X=12, Y=8, out_ready=1 → (4,8), (4,4); out=4, steps=2, out_valid high exactly 3 edges after accept, then IDLE.
- MODE 1, X=12, Y=8 → sequence (6,4,k1), (3,2,k2), (3,1), (2,1), (1,1); out=4, steps=5. Repeat with random 32-bit pairs in both modes against a reference GCD model; results must match.
- X=0, Y=5 → out=5, steps=0. X=0, Y=0 → out=0. X=7, Y=7 → out=7, steps=0, 1-cycle latency.
- CNT_W=4, MODE 0, X=1, Y=20 → out=1, steps saturates at 15 (true count 19).
- Hold out_ready=0 for 10 cycles in DONE → out_valid and out stable, in_ready=0, and in_valid pulses are ignored. Release out_ready → IDLE, and the next pair is accepted only after that.
- Assert reset low asynchronously mid-RUN (X=1000, Y=3) → immediately out_valid=0, out=0, steps=0, in_ready=1. A fresh X=9, Y=6 then yields out=3.

Source files
------------

// File: rtl/gcd_unit.sv
`default_nettype none
// ============================================================================
// Module      : gcd_unit
// Description : Self-sequencing GCD engine. Accepts an operand pair over a
//               valid/ready handshake, iterates to the greatest common divisor
//               with either subtractive Euclid (MODE 0) or binary Stein
//               (MODE 1), and presents the result over a second handshake.
//
// Ports       : clock      - sole clock, rising edge
//               reset      - asynchronous active-low reset
//               in_valid   - operand pair X/Y valid
//               in_ready   - block can accept a pair (high in IDLE only)
//               X, Y       - unsigned operands, sampled at the accept edge
//               out_valid  - result valid (high in DONE only)
//               out_ready  - consumer accepts the result
//               out        - registered GCD result
//               steps      - registered, saturating iteration count
//               busy       - high while iterating (RUN)
//
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int MODE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] steps,
  output logic             busy
);

  // Shift count must reach WIDTH-1 in the binary algorithm.
  localparam int c_KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_x, w_x_nxt;
  logic [WIDTH-1:0]   r_y, w_y_nxt;
  logic [c_KW-1:0]    r_k, w_k_nxt;
  logic [WIDTH-1:0]   r_out, w_out_nxt;
  logic [CNT_W-1:0]   r_steps, w_steps_nxt;
  logic [CNT_W-1:0]   w_steps_inc;

  // Iteration counter sticks at all-ones rather than wrapping.
  assign w_steps_inc = (r_steps == {CNT_W{1'b1}}) ? r_steps : r_steps + CNT_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_out   <= '0;
      r_steps <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_k     <= w_k_nxt;
      r_out   <= w_out_nxt;
      r_steps <= w_steps_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_k_nxt     = r_k;
    w_out_nxt   = r_out;
    w_steps_nxt = r_steps;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_x_nxt     = X;
          w_y_nxt     = Y;
          w_k_nxt     = '0;
          w_steps_nxt = '0;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (r_x == '0 || r_y == '0) begin
          // A zero operand can only be present on the first RUN cycle, so
          // k is still 0 here; the OR simply selects the non-zero operand.
          w_out_nxt   = (r_x | r_y) << r_k;
          w_state_nxt = S_DONE;
        end else if (r_x == r_y) begin
          // Reapply the common factors of two stripped by the binary method.
          w_out_nxt   = r_x << r_k;
          w_state_nxt = S_DONE;
        end else begin
          w_steps_nxt = w_steps_inc;
          if (MODE == 0) begin
            if (r_x > r_y) w_x_nxt = r_x - r_y;
            else           w_y_nxt = r_y - r_x;
          end else begin
            if (!r_x[0] && !r_y[0]) begin
              w_x_nxt = r_x >> 1;
              w_y_nxt = r_y >> 1;
              w_k_nxt = r_k + c_KW'(1);
            end else if (!r_x[0]) begin
              w_x_nxt = r_x >> 1;
            end else if (!r_y[0]) begin
              w_y_nxt = r_y >> 1;
            end else if (r_x > r_y) begin
              w_x_nxt = r_x - r_y;
            end else begin
              w_y_nxt = r_y - r_x;
            end
          end
        end
      end

      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign out       = r_out;
  assign steps     = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_gcd_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_unit
// Description : Self-checking bench for gcd_unit. Three instances share clock
//               and reset: MODE 0, MODE 1, and MODE 0 with a 4-bit counter.
//               Results are compared against a behavioural GCD model.
//
// Ports       : none
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_unit;

  localparam int c_TIMEOUT = 3000;

  logic        clk;
  logic        rst_n;
  logic        iv   [3];
  logic        ordy [3];
  logic [31:0] xa   [3];
  logic [31:0] ya   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        bz   [3];
  logic [31:0] res  [3];
  logic [15:0] st   [3];
  logic [3:0]  st4;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_unit #(.WIDTH(32), .CNT_W(16), .MODE(0)) u_dut_m0 (
    .clock(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .X(xa[0]), .Y(ya[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out(res[0]), .steps(st[0]), .busy(bz[0])
  );

  gcd_unit #(.WIDTH(32), .CNT_W(16), .MODE(1)) u_dut_m1 (
    .clock(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .X(xa[1]), .Y(ya[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out(res[1]), .steps(st[1]), .busy(bz[1])
  );

  gcd_unit #(.WIDTH(32), .CNT_W(4), .MODE(0)) u_dut_c4 (
    .clock(clk), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .X(xa[2]), .Y(ya[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out(res[2]), .steps(st4), .busy(bz[2])
  );

  assign st[2] = {12'd0, st4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive Euclid does q subtractions per division step, except the
  // final exact division which stops one short at (g, g).
  function automatic longint unsigned ref_sub_steps(input longint unsigned a, input longint unsigned b);
    longint unsigned sum, t;
    if (a == 0 || b == 0) return 0;
    sum = 0;
    while (b != 0) begin
      sum += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return sum - 1;
  endfunction

  function automatic longint unsigned ref_bin_steps(input longint unsigned a, input longint unsigned b);
    longint unsigned n;
    n = 0;
    while (a != 0 && b != 0 && a != b) begin
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one pair to instance d, waits for the result and consumes it.
  task automatic run(input string tag, input int d, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, output logic [31:0] r, output logic [15:0] s);
    int lat;
    @(negedge clk);
    ordy[d] = 1'b1;
    iv[d]   = 1'b1;
    xa[d]   = a;
    ya[d]   = b;
    check({tag, "_in_ready"}, 64'(ir[d]), 64'd1);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    xa[d] = $urandom;      // operands must only be sampled at accept
    ya[d] = $urandom;
    lat = 0;
    while (!ov[d] && lat < c_TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    r = res[d];
    s = st[d];
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, 64'(ir[d]), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic [15:0] s;
    logic [31:0] a, b;
    longint unsigned es;
    int lat;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; xa[i] = '0; ya[i] = '0;
    end
    #22;
    check("rst_in_ready",  64'(ir[0]), 64'd1);
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_busy",      64'(bz[0]), 64'd0);
    check("rst_out",       64'(res[0]), 64'd0);
    check("rst_steps",     64'(st[0]), 64'd0);
    check("rst_busy_m1",   64'(bz[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run("m0_12_8", 0, 32'd12, 32'd8, 3, r, s);
    check("m0_12_8_out", 64'(r), 64'd4);
    check("m0_12_8_steps", 64'(s), 64'd2);

    run("m1_12_8", 1, 32'd12, 32'd8, 6, r, s);
    check("m1_12_8_out", 64'(r), 64'd4);
    check("m1_12_8_steps", 64'(s), 64'd5);

    run("m0_0_5", 0, 32'd0, 32'd5, 1, r, s);
    check("m0_0_5_out", 64'(r), 64'd5);
    check("m0_0_5_steps", 64'(s), 64'd0);

    run("m1_0_5", 1, 32'd0, 32'd5, 1, r, s);
    check("m1_0_5_out", 64'(r), 64'd5);

    run("m0_0_0", 0, 32'd0, 32'd0, 1, r, s);
    check("m0_0_0_out", 64'(r), 64'd0);

    run("m1_7_7", 1, 32'd7, 32'd7, 1, r, s);
    check("m1_7_7_out", 64'(r), 64'd7);
    check("m1_7_7_steps", 64'(s), 64'd0);

    run("m0_7_7", 0, 32'd7, 32'd7, 1, r, s);
    check("m0_7_7_out", 64'(r), 64'd7);

    run("c4_1_20", 2, 32'd1, 32'd20, 20, r, s);
    check("c4_1_20_out", 64'(r), 64'd1);
    check("c4_1_20_steps_sat", 64'(s), 64'd15);

    // Random pairs, MODE 0: built from a common factor and small cofactors
    // so the subtractive iteration count stays bounded.
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(1000, 1) * $urandom_range(200, 1);
      b = 32'(a / $urandom_range(200, 1)) + 32'($urandom_range(3, 0));
      if (i % 2 == 1) begin
        logic [31:0] g;
        g = $urandom_range(1000, 1);
        a = g * $urandom_range(200, 1);
        b = g * $urandom_range(200, 1);
      end
      es = ref_sub_steps(a, b);
      run("m0_rand", 0, a, b, int'(es) + 1, r, s);
      check("m0_rand_out", 64'(r), ref_gcd(a, b));
      check("m0_rand_steps", 64'(s), es);
    end

    // Random full-width pairs, MODE 1
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) begin
        a = a << $urandom_range(8, 0);
        b = b << $urandom_range(8, 0);
      end
      es = ref_bin_steps(a, b);
      run("m1_rand", 1, a, b, int'(es) + 1, r, s);
      check("m1_rand_out", 64'(r), ref_gcd(a, b));
      check("m1_rand_steps", 64'(s), es);
    end

    // Back-pressure: result held in DONE, new requests ignored
    @(negedge clk);
    ordy[0] = 1'b0;
    iv[0]   = 1'b1;
    xa[0]   = 32'd12;
    ya[0]   = 32'd8;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < c_TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_latency", 64'(lat), 64'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      xa[0] = 32'd99;
      ya[0] = 32'd33;
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(ov[0]), 64'd1);
      check("hold_out", 64'(res[0]), 64'd4);
      check("hold_steps", 64'(st[0]), 64'd2);
      check("hold_in_ready", 64'(ir[0]), 64'd0);
    end
    @(negedge clk);
    iv[0]   = 1'b1;
    xa[0]   = 32'd9;
    ya[0]   = 32'd6;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(ir[0]), 64'd1);
    check("release_busy", 64'(bz[0]), 64'd0);
    check("release_out_valid", 64'(ov[0]), 64'd0);
    @(posedge clk);
    #1;
    check("next_accept_busy", 64'(bz[0]), 64'd1);
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < c_TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("next_latency", 64'(lat), 64'd3);
    check("next_out", 64'(res[0]), 64'd3);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a long computation
    @(negedge clk);
    iv[0] = 1'b1;
    xa[0] = 32'd1000;
    ya[0] = 32'd3;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_busy", 64'(bz[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(ov[0]), 64'd0);
    check("arst_out", 64'(res[0]), 64'd0);
    check("arst_steps", 64'(st[0]), 64'd0);
    check("arst_in_ready", 64'(ir[0]), 64'd1);
    check("arst_busy", 64'(bz[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_9_6", 0, 32'd9, 32'd6, 3, r, s);
    check("post_rst_out", 64'(r), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
